// File: rtl/mem_stage_if.sv
// Signal bundle between execute, the memory stage, the data bus and writeback.
// The slave modport is the stage itself; master is the surrounding pipeline/bus.
interface mem_stage_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic        mem_en;
  logic        mem_we;
  logic [2:0]  mem_op;
  logic [4:0]  rd_in;
  logic        wb_en_in;

  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  logic        wb_valid;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign;
  logic        bus_err;

  modport slave (
    input  ex_valid, alu_result, store_data, mem_en, mem_we, mem_op, rd_in, wb_en_in,
    input  bus_ack, bus_rdata,
    output ex_ready, bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output wb_valid, wb_en, wb_rd, wb_data, misalign, bus_err
  );

  modport master (
    output ex_valid, alu_result, store_data, mem_en, mem_we, mem_op, rd_in, wb_en_in,
    output bus_ack, bus_rdata,
    input  ex_ready, bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  wb_valid, wb_en, wb_rd, wb_data, misalign, bus_err
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: drives a req/ack data bus for loads/stores, aligns and extends
// load data, and emits one registered writeback record per accepted instruction.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  mif
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUS  = 1'b1;
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [0:0]    state_reg;
  logic [CW-1:0] cnt_reg;
  logic [31:0]   addr_reg;
  logic [31:0]   wdata_reg;
  logic [3:0]    wstrb_reg;
  logic          we_reg;
  logic [2:0]    op_reg;
  logic [4:0]    rd_reg;
  logic          wben_reg;

  logic          wb_valid_reg;
  logic          wb_en_reg;
  logic [4:0]    wb_rd_reg;
  logic [31:0]   wb_data_reg;
  logic          misalign_reg;
  logic          bus_err_reg;

  logic          in_bus;
  logic          accept;
  logic          misal;
  logic [31:0]   st_wdata;
  logic [3:0]    st_wstrb;
  logic [7:0]    rd_byte [4];
  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;
  logic [31:0]   ld_data;

  assign in_bus = (state_reg == BUS);
  assign accept = mif.ex_valid && (state_reg == IDLE);

  assign mif.ex_ready  = (state_reg == IDLE);
  assign mif.bus_req   = in_bus;
  assign mif.bus_we    = in_bus & we_reg;
  assign mif.bus_addr  = in_bus ? {addr_reg[31:2], 2'b00} : 32'h0;
  assign mif.bus_wdata = in_bus ? wdata_reg : 32'h0;
  assign mif.bus_wstrb = in_bus ? wstrb_reg : 4'h0;

  assign mif.wb_valid = wb_valid_reg;
  assign mif.wb_en    = wb_en_reg;
  assign mif.wb_rd    = wb_rd_reg;
  assign mif.wb_data  = wb_data_reg;
  assign mif.misalign = misalign_reg;
  assign mif.bus_err  = bus_err_reg;

  // mem_op[1:0] carries the access size; mem_op[2] only selects zero-extension
  always_comb begin
    misal = 1'b0;
    if (mif.mem_en) begin
      case (mif.mem_op[1:0])
        2'b01:   misal = mif.alu_result[0];
        2'b10:   misal = (mif.alu_result[1:0] != 2'b00);
        default: misal = 1'b0;
      endcase
    end
  end

  always_comb begin
    st_wdata = mif.store_data;
    st_wstrb = 4'b1111;
    case (mif.mem_op[1:0])
      2'b00: begin
        st_wdata = {4{mif.store_data[7:0]}};
        st_wstrb = 4'b0001 << mif.alu_result[1:0];
      end
      2'b01: begin
        st_wdata = {2{mif.store_data[15:0]}};
        st_wstrb = 4'b0011 << mif.alu_result[1:0];
      end
      default: begin
        st_wdata = mif.store_data;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rd_byte[gi] = mif.bus_rdata[8*gi +: 8];
    end
  endgenerate

  assign sel_byte = rd_byte[addr_reg[1:0]];
  assign sel_half = addr_reg[1] ? mif.bus_rdata[31:16] : mif.bus_rdata[15:0];

  always_comb begin
    case (op_reg[1:0])
      2'b00:   ld_data = {{24{sel_byte[7] & ~op_reg[2]}}, sel_byte};
      2'b01:   ld_data = {{16{sel_half[15] & ~op_reg[2]}}, sel_half};
      default: ld_data = mif.bus_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      addr_reg     <= 32'h0;
      wdata_reg    <= 32'h0;
      wstrb_reg    <= 4'h0;
      we_reg       <= 1'b0;
      op_reg       <= 3'b000;
      rd_reg       <= 5'd0;
      wben_reg     <= 1'b0;
      wb_valid_reg <= 1'b0;
      wb_en_reg    <= 1'b0;
      wb_rd_reg    <= 5'd0;
      wb_data_reg  <= 32'h0;
      misalign_reg <= 1'b0;
      bus_err_reg  <= 1'b0;
    end else begin
      wb_valid_reg <= 1'b0;
      wb_en_reg    <= 1'b0;
      wb_rd_reg    <= 5'd0;
      wb_data_reg  <= 32'h0;
      misalign_reg <= 1'b0;
      bus_err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (!mif.mem_en) begin
              wb_valid_reg <= 1'b1;
              wb_data_reg  <= mif.alu_result;
              wb_rd_reg    <= mif.rd_in;
              wb_en_reg    <= mif.wb_en_in;
            end else if (misal) begin
              wb_valid_reg <= 1'b1;
              misalign_reg <= 1'b1;
              wb_rd_reg    <= mif.rd_in;
            end else begin
              state_reg <= BUS;
              cnt_reg   <= '0;
              addr_reg  <= mif.alu_result;
              we_reg    <= mif.mem_we;
              op_reg    <= mif.mem_op;
              rd_reg    <= mif.rd_in;
              wben_reg  <= mif.wb_en_in;
              wdata_reg <= mif.mem_we ? st_wdata : 32'h0;
              wstrb_reg <= mif.mem_we ? st_wstrb : 4'h0;
            end
          end
        end
        default: begin
          // ack is checked first so an ack on the final counted cycle still completes
          if (mif.bus_ack) begin
            state_reg    <= IDLE;
            wb_valid_reg <= 1'b1;
            wb_rd_reg    <= rd_reg;
            wb_en_reg    <= wben_reg & ~we_reg;
            wb_data_reg  <= we_reg ? 32'h0 : ld_data;
          end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
            state_reg    <= IDLE;
            wb_valid_reg <= 1'b1;
            bus_err_reg  <= 1'b1;
            wb_rd_reg    <= rd_reg;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected writeback records are queued at issue
// and popped by a negedge monitor whenever wb_valid is seen.
module tb_mem_stage;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_stage_if mif();

  mem_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .mif (mif)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        en;
    logic        mis;
    logic        err;
    logic        chk_rd;
    logic        chk_data;
  } wb_t;

  wb_t sb_q[$];
  wb_t mon_e;
  int  checks   = 0;
  int  failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (mif.wb_valid) begin
        if (sb_q.size() == 0) begin
          check_eq("wb_unexpected", mif.wb_valid, 0);
        end else begin
          mon_e = sb_q.pop_front();
          $display("wb rd=%0d data=%h en=%0b mis=%0b err=%0b", mif.wb_rd, mif.wb_data,
                   mif.wb_en, mif.misalign, mif.bus_err);
          check_eq("wb_en", mif.wb_en, mon_e.en);
          check_eq("wb_misalign", mif.misalign, mon_e.mis);
          check_eq("wb_bus_err", mif.bus_err, mon_e.err);
          if (mon_e.chk_rd)   check_eq("wb_rd", mif.wb_rd, mon_e.rd);
          if (mon_e.chk_data) check_eq("wb_data", mif.wb_data, mon_e.data);
        end
      end else begin
        check_eq("flag_without_wb", {mif.misalign, mif.bus_err}, 0);
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!mif.ex_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!mif.ex_ready) check_eq("ready_timeout", mif.ex_ready, 1);
  endtask

  task automatic drive_ex(input logic en, input logic we, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] sd,
                          input logic [4:0] rd, input logic wben);
    mif.ex_valid   = 1'b1;
    mif.mem_en     = en;
    mif.mem_we     = we;
    mif.mem_op     = op;
    mif.alu_result = a;
    mif.store_data = sd;
    mif.rd_in      = rd;
    mif.wb_en_in   = wben;
  endtask

  task automatic pass_op(input logic [31:0] val, input logic [4:0] rd, input logic wben);
    wb_t e;
    e = '{rd: rd, data: val, en: wben, mis: 1'b0, err: 1'b0, chk_rd: 1'b1, chk_data: 1'b1};
    wait_ready();
    drive_ex(1'b0, 1'b0, 3'b010, val, 32'h0, rd, wben);
    sb_q.push_back(e);
    @(negedge clk);
    mif.ex_valid = 1'b0;
    check_eq("pass_latency", mif.wb_valid, 1);
  endtask

  // ack_dly: number of bus_req cycles before ack is given (1 = ack in first cycle), <0 = never
  task automatic mem_access(input logic we, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] sd, input logic [4:0] rd, input logic wben,
                            input int ack_dly, input logic [31:0] rdata);
    wb_t e;
    logic mis;
    logic ack;
    logic [3:0] strb;
    logic [31:0] wd;
    logic [31:0] sh;
    int n;
    mis  = (op[1:0] == 2'b01 && addr[0]) || (op[1:0] == 2'b10 && addr[1:0] != 2'b00);
    strb = 4'h0;
    wd   = sd;
    case (op[1:0])
      2'b00: begin strb[addr[1:0]] = 1'b1; wd = {4{sd[7:0]}}; end
      2'b01: begin strb[addr[1:0]] = 1'b1; strb[addr[1:0] + 1] = 1'b1; wd = {2{sd[15:0]}}; end
      default: strb = 4'hF;
    endcase
    sh = rdata >> (8 * addr[1:0]);
    e.rd       = rd;
    e.mis      = mis;
    e.err      = !mis && (ack_dly < 0);
    e.en       = !mis && (ack_dly >= 0) && !we && wben;
    e.chk_rd   = !mis && !e.err;
    e.chk_data = e.chk_rd && !we;
    case (op)
      3'b000:  e.data = {{24{sh[7]}}, sh[7:0]};
      3'b100:  e.data = {24'h0, sh[7:0]};
      3'b001:  e.data = {{16{sh[15]}}, sh[15:0]};
      3'b101:  e.data = {16'h0, sh[15:0]};
      default: e.data = rdata;
    endcase

    wait_ready();
    drive_ex(1'b1, we, op, addr, sd, rd, wben);
    sb_q.push_back(e);
    @(negedge clk);
    mif.ex_valid = 1'b0;
    if (mis) begin
      check_eq("mis_no_req", mif.bus_req, 0);
      check_eq("mis_latency", mif.wb_valid, 1);
      return;
    end
    check_eq("req_on", mif.bus_req, 1);
    check_eq("bus_addr", mif.bus_addr, {addr[31:2], 2'b00});
    check_eq("bus_we", mif.bus_we, we);
    check_eq("bus_wstrb", mif.bus_wstrb, we ? strb : 4'h0);
    if (we) check_eq("bus_wdata", mif.bus_wdata, wd);
    n = 0;
    forever begin
      n++;
      ack = (n == ack_dly);
      mif.bus_ack   = ack;
      mif.bus_rdata = ack ? rdata : 32'hDEAD_BEEF;
      @(negedge clk);
      mif.bus_ack = 1'b0;
      if (ack || n == TIMEOUT) begin
        check_eq("req_drop", mif.bus_req, 0);
        check_eq("wb_latency", mif.wb_valid, 1);
        break;
      end
      check_eq("req_hold", mif.bus_req, 1);
      if (!mif.bus_req) break;
      check_eq("addr_hold", mif.bus_addr, {addr[31:2], 2'b00});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    mif.ex_valid   = 1'b0;
    mif.alu_result = 32'h0;
    mif.store_data = 32'h0;
    mif.mem_en     = 1'b0;
    mif.mem_we     = 1'b0;
    mif.mem_op     = 3'b000;
    mif.rd_in      = 5'd0;
    mif.wb_en_in   = 1'b0;
    mif.bus_ack    = 1'b0;
    mif.bus_rdata  = 32'h0;
    repeat (2) @(negedge clk);
    check_eq("rst_ex_ready", mif.ex_ready, 1);
    check_eq("rst_bus_req", mif.bus_req, 0);
    check_eq("rst_wb_valid", mif.wb_valid, 0);
    check_eq("rst_bus_wstrb", mif.bus_wstrb, 0);
    check_eq("rst_flags", {mif.misalign, mif.bus_err, mif.wb_en}, 0);
    rst = 1'b0;
    @(negedge clk);

    pass_op(32'h1234_5678, 5'd5, 1'b1);
    pass_op(32'hCAFE_0001, 5'd9, 1'b0);

    mem_access(1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd1, 1'b1, 2, 32'h80FF_0000);  // LB
    mem_access(1'b0, 3'b101, 32'h0000_0102, 32'h0, 5'd2, 1'b1, 1, 32'hBEEF_1234);  // LHU
    mem_access(1'b0, 3'b001, 32'h0000_0102, 32'h0, 5'd3, 1'b1, 3, 32'hBEEF_1234);  // LH
    mem_access(1'b0, 3'b100, 32'h0000_0101, 32'h0, 5'd4, 1'b1, 1, 32'h1122_F344);  // LBU
    mem_access(1'b0, 3'b010, 32'h0000_0400, 32'h0, 5'd6, 1'b1, 1, 32'h89AB_CDEF);  // LW
    mem_access(1'b1, 3'b000, 32'h0000_0201, 32'h0000_00AB, 5'd7, 1'b1, 1, 32'h0);  // SB
    mem_access(1'b1, 3'b001, 32'h0000_0202, 32'h1234_CDEF, 5'd8, 1'b1, 2, 32'h0);  // SH
    mem_access(1'b1, 3'b010, 32'h0000_0300, 32'h5555_AAAA, 5'd8, 1'b1, 1, 32'h0);  // SW
    mem_access(1'b0, 3'b010, 32'h0000_0103, 32'h0, 5'd10, 1'b1, 1, 32'h0);         // LW misaligned
    mem_access(1'b0, 3'b001, 32'h0000_0101, 32'h0, 5'd11, 1'b1, 1, 32'h0);         // LH misaligned
    mem_access(1'b1, 3'b010, 32'h0000_0302, 32'h1, 5'd12, 1'b0, 1, 32'h0);         // SW misaligned
    mem_access(1'b0, 3'b010, 32'h0000_0500, 32'h0, 5'd13, 1'b1, -1, 32'h0);        // timeout
    mem_access(1'b0, 3'b010, 32'h0000_0504, 32'h0, 5'd14, 1'b1, TIMEOUT, 32'h0BAD_F00D);

    // accept in the same cycle the previous bus writeback is presented
    mem_access(1'b0, 3'b000, 32'h0000_0600, 32'h0, 5'd15, 1'b1, 1, 32'h0000_007F);
    check_eq("ready_on_wb", mif.ex_ready, 1);
    pass_op(32'h0000_00AA, 5'd16, 1'b1);

    // back-to-back pass-through accepts
    for (int i = 0; i < 4; i++) begin
      wb_t e;
      e = '{rd: 5'(20 + i), data: 32'h1000_0000 + 32'(i), en: 1'b1, mis: 1'b0, err: 1'b0,
            chk_rd: 1'b1, chk_data: 1'b1};
      drive_ex(1'b0, 1'b0, 3'b010, e.data, 32'h0, e.rd, 1'b1);
      sb_q.push_back(e);
      @(negedge clk);
      check_eq("b2b_wb_valid", mif.wb_valid, 1);
    end
    mif.ex_valid = 1'b0;
    @(negedge clk);

    // ack while idle must be ignored
    mif.bus_ack   = 1'b1;
    mif.bus_rdata = 32'h7777_7777;
    @(negedge clk);
    mif.bus_ack = 1'b0;
    check_eq("idle_ack_req", mif.bus_req, 0);
    check_eq("idle_ack_wb", mif.wb_valid, 0);

    // reset raised in the middle of a bus transaction
    drive_ex(1'b1, 1'b0, 3'b010, 32'h0000_0700, 32'h0, 5'd30, 1'b1);
    @(negedge clk);
    mif.ex_valid = 1'b0;
    check_eq("rst_mid_req_on", mif.bus_req, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst_mid_req_off", mif.bus_req, 0);
    check_eq("rst_mid_ready", mif.ex_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_mid_no_wb", mif.wb_valid, 0);
    end

    check_eq("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
